// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants, FSM encoding and byte-level helper functions
package aes_pkg;
  localparam int AES_NROUNDS = 10;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_fsm_e;
  function automatic logic [7:0] aes_rcon(input logic [3:0] r);
    return (r >= 4'd1 && r <= 4'd8) ? 8'(8'h01 << (r - 4'd1)) :
           r == 4'd9 ? 8'h1b : r == 4'd10 ? 8'h36 : 8'h00;
  endfunction
  function automatic logic [127:0] aes_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction
  function automatic logic [7:0] aes_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] aes_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = aes_xtime(x);
    end
    return p;
  endfunction
  // Multiplicative inverse as a^254 (0 maps to 0), then the FIPS-197 affine map
  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = aes_gmul(sq, sq);
      inv = aes_gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/S4.sv
// S4: four parallel AES S-boxes over one 32-bit word
module S4 import aes_pkg::*; (
  input  logic [31:0] x,
  output logic [31:0] y
);
  for (genvar k = 0; k < 4; k++) begin : g_sb
    assign y[31-8*k -: 8] = aes_sbox(x[31-8*k -: 8]);
  end
endmodule

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step from the previous round key
module aes_key_step (
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);
  logic [31:0] sub, t, w0, w1, w2, w3;
  S4 u_s4 (.x({key[23:0], key[31:24]}), .y(sub));
  assign t  = sub ^ {rcon, 24'h0};
  assign w0 = key[127:96] ^ t;
  assign w1 = key[95:64] ^ w0;
  assign w2 = key[63:32] ^ w1;
  assign w3 = key[31:0] ^ w2;
  assign next_key = {w0, w1, w2, w3};
endmodule

// File: rtl/table_lookup.sv
// table_lookup: SubBytes+MixColumns T-table contributions of one state word, one per row position
module table_lookup import aes_pkg::*; (
  input  logic [31:0] state,
  output logic [31:0] p0,
  output logic [31:0] p1,
  output logic [31:0] p2,
  output logic [31:0] p3
);
  logic [7:0] s [4];
  logic [7:0] d [4];
  logic [7:0] t [4];
  for (genvar k = 0; k < 4; k++) begin : g_b
    assign s[k] = aes_sbox(state[31-8*k -: 8]);
    assign d[k] = aes_xtime(s[k]);
    assign t[k] = d[k] ^ s[k];
  end
  assign p0 = {d[0], s[0], s[0], t[0]};
  assign p1 = {t[1], d[1], s[1], s[1]};
  assign p2 = {s[2], t[2], d[2], s[2]};
  assign p3 = {s[3], s[3], t[3], d[3]};
endmodule

// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encryptor, one round per clock, on-the-fly key expansion
module aes128_iter_core import aes_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  aes_fsm_e     fsm_q;
  logic [127:0] state_q, key_q, k_r, sr, mix, last, nxt;
  logic [3:0]   round_q;
  logic [7:0]   rcon;
  logic [31:0]  p0 [4];
  logic [31:0]  p1 [4];
  logic [31:0]  p2 [4];
  logic [31:0]  p3 [4];
  assign rcon = aes_rcon(round_q);
  aes_key_step u_ks (.key(key_q), .rcon(rcon), .next_key(k_r));
  assign sr = aes_shift_rows(state_q);
  for (genvar i = 0; i < 4; i++) begin : g_col
    table_lookup u_tl (
      .state(state_q[127-32*i -: 32]),
      .p0(p0[i]), .p1(p1[i]), .p2(p2[i]), .p3(p3[i])
    );
    S4 u_s4 (.x(sr[127-32*i -: 32]), .y(last[127-32*i -: 32]));
    assign mix[127-32*i -: 32] = p0[i] ^ p1[(i+1)%4] ^ p2[(i+2)%4] ^ p3[(i+3)%4] ^ k_r[127-32*i -: 32];
  end
  // Final round skips MixColumns, so it takes the plain S-box path
  assign nxt = round_q == 4'(AES_NROUNDS) ? last ^ k_r : mix;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else
      case (fsm_q)
        IDLE: if (in_valid) begin
          state_q <= in_state ^ in_key;
          key_q   <= in_key;
          round_q <= 4'd1;
          fsm_q   <= ROUND;
        end
        ROUND: begin
          state_q <= nxt;
          key_q   <= k_r;
          if (round_q == 4'(AES_NROUNDS)) fsm_q <= DONE;
          else round_q <= round_q + 4'd1;
        end
        DONE: if (out_ready) fsm_q <= IDLE;
        default: fsm_q <= IDLE;
      endcase
  assign in_ready  = fsm_q == IDLE;
  assign out_valid = fsm_q == DONE;
  assign out_data  = state_q;
endmodule
